// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction fetch front end. Requests aligned cache lines from memory,
//   slices each line into 32-bit words tagged with their PCs, and buffers them
//   in a DEPTH-entry FIFO that the decoder drains through out_valid/out_ready.
//   A redirect flushes the queue and restarts fetch at the new PC.
//   Optional feature macro: FETCH_HALT_ON_ZERO_EN. When it is defined, a zero
//   instruction word parks the fetcher in HALT instead of being queued.
module fetch_queue_unit #(
  parameter int LINE_BITS = 512,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      entry,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   mem_req_valid,
  output logic [ADDR_W-1:0]      mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_resp_valid,
  input  logic [LINE_BITS-1:0]   mem_resp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   halted
);

  localparam int INSTR_PER_LINE = LINE_BITS / 32;
  localparam int OFF_W          = $clog2(LINE_BITS / 8);  // byte-offset bits within a line
  localparam int IDX_W          = OFF_W - 2;              // word-index bits within a line
  localparam int PTR_W          = $clog2(DEPTH);
  localparam int OCC_W          = PTR_W + 1;

  // S_IDLE is the reset state; it loads entry and hands over to S_REQ.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_HALT
  } state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  logic [ADDR_W-1:0]               r_fetch_pc;
  logic [INSTR_PER_LINE-1:0][31:0] r_line;
  logic                            r_drop_resp;

  logic [31:0]                     r_instr_mem [DEPTH];
  logic [ADDR_W-1:0]               r_pc_mem    [DEPTH];
  logic [PTR_W-1:0]                r_wr_ptr;
  logic [PTR_W-1:0]                r_rd_ptr;
  logic [OCC_W-1:0]                r_count;

  logic [IDX_W-1:0]                w_idx;
  logic [31:0]                     w_word;
  logic                            w_last;
  logic                            w_empty;
  logic                            w_full;
  logic                            w_pop;
  logic                            w_push;
  logic                            w_zero_word;
  logic                            w_resp_take;
  logic                            w_req_fire;

  // Current word slot is addressed straight from the fetch PC line offset.
  assign w_idx       = r_fetch_pc[OFF_W-1:2];
  assign w_word      = r_line[w_idx];
  assign w_last      = (w_idx == {IDX_W{1'b1}});

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == OCC_W'(DEPTH));
  assign w_pop       = out_valid && out_ready;
  assign w_req_fire  = mem_req_valid && mem_req_ready;

  // A response that coincides with a redirect belongs to the old stream.
  assign w_resp_take = (r_state == S_WAIT) && mem_resp_valid && !redirect_valid;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign w_zero_word = (r_state == S_FILL) && (w_word == 32'h0);
  assign halted      = (r_state == S_HALT) && w_empty;
`else
  assign w_zero_word = 1'b0;
  assign halted      = 1'b0;
`endif

  // A slot frees up either because the queue is not full or because the
  // head leaves in the same cycle.
  assign w_push = (r_state == S_FILL) && (!w_full || w_pop) &&
                  !w_zero_word && !redirect_valid;

  // Next-state and memory-request decode; redirect overrides everything.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and a latch is never inferred.
    w_next_state  = r_state;
    mem_req_valid = 1'b0;
    case (r_state)
      S_IDLE: w_next_state = S_REQ;
      S_REQ: begin
        // Hold the request while a stale response is still in flight so
        // that at most one request is ever outstanding.
        mem_req_valid = !r_drop_resp;
        if (w_req_fire) w_next_state = S_WAIT;
      end
      S_WAIT: if (mem_resp_valid) w_next_state = S_FILL;
      S_FILL: begin
        if (w_zero_word)         w_next_state = S_HALT;
        else if (w_push && w_last) w_next_state = S_REQ;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
    if (redirect_valid) w_next_state = S_REQ;
  end

  assign mem_req_addr = mem_req_valid ? {r_fetch_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Fetch PC: entry after reset, redirect target, or advance one word per push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_fetch_pc <= '0;
    else if (redirect_valid)    r_fetch_pc <= redirect_pc & ~ADDR_W'(3);
    else if (r_state == S_IDLE) r_fetch_pc <= entry & ~ADDR_W'(3);
    else if (w_push)            r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
  end

  // Remember that the next response belongs to a request made before a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_resp <= 1'b0;
    end else if (redirect_valid) begin
      r_drop_resp <= ((r_state == S_WAIT) && !mem_resp_valid) || w_req_fire ||
                     (r_drop_resp && !mem_resp_valid);
    end else if (mem_resp_valid) begin
      r_drop_resp <= 1'b0;
    end
  end

  // Line buffer capture; contents are only read in FILL after a fresh capture.
  always_ff @(posedge clk) begin
    if (w_resp_take) r_line <= mem_resp_data;
  end

  // FIFO pointers and occupancy; redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; entries are never observed
    // until written because the outputs are gated by the occupancy count.
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= w_word;
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  assign out_valid = !w_empty;
  assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign occupancy = r_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
//   Directed bench for fetch_queue_unit. A memory responder serves line
//   requests from an address-derived pattern; a behavioural model tracks the
//   fetch PC at line granularity and the ordered list of words the decoder
//   must see, and a single compare process checks the DUT every cycle.
//   Build with FETCH_HALT_ON_ZERO_EN defined to run the halt scenario too.
module tb_fetch_queue_unit;

  localparam int LINE_BITS = 512;
  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 64;
  localparam int WPL       = LINE_BITS / 32;
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BITS / 8 - 1);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic                   clk;
  logic                   reset;
  logic [ADDR_W-1:0]      entry;
  logic                   redirect_valid;
  logic [ADDR_W-1:0]      redirect_pc;
  logic                   mem_req_valid;
  logic [ADDR_W-1:0]      mem_req_addr;
  logic                   mem_req_ready;
  logic                   mem_resp_valid;
  logic [LINE_BITS-1:0]   mem_resp_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_instr;
  logic [ADDR_W-1:0]      out_pc;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   halted;

  fetch_queue_unit #(.LINE_BITS(LINE_BITS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .occupancy      (occupancy),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: word at byte address a holds 0x13 + (a-0x1000)/4, except
  // an optional planted zero word.
  logic [63:0] zero_addr = '1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] v;
    if (a == zero_addr) return 32'h0;
    v = ((a - 64'h1000) >> 2) + 64'h13;
    return v[31:0];
  endfunction

  function automatic logic [LINE_BITS-1:0] make_line(input logic [63:0] base);
    logic [LINE_BITS-1:0] d;
    for (int i = 0; i < WPL; i++) d[32*i +: 32] = mem_word(base + 64'(4 * i));
    return d;
  endfunction

  // ---------------- memory responder ----------------
  int          resp_lat = 1;
  bit          pend     = 0;
  int          pend_cnt = 0;
  logic [63:0] pend_addr;
  bit          acc_s;
  logic [63:0] acc_addr;

  always begin
    @(negedge clk);
    acc_s    = reset && mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    if (!reset) begin
      pend = 0;
    end else begin
      if (pend) begin
        if (pend_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = make_line(pend_addr);
          pend           = 0;
        end else begin
          pend_cnt--;
        end
      end
      if (acc_s) begin
        pend      = 1;
        pend_addr = acc_addr;
        pend_cnt  = resp_lat - 1;
      end
    end
  end

  // ---------------- behavioural model + compare process ----------------
  ent_t        exp_q[$];
  ent_t        pop_log[$];
  logic [63:0] req_log[$];
  logic [63:0] m_pc;
  bit          m_out, m_drop, m_halt;
  int          resp_cyc     = -1;
  int          first_ov_cyc = -1;

  always @(negedge clk) begin
    if (!reset) begin
      check("reset_out_valid", {63'h0, out_valid}, 64'h0);
      check("reset_occupancy", 64'(occupancy), 64'h0);
      check("reset_req_valid", {63'h0, mem_req_valid}, 64'h0);
      exp_q.delete();
      pop_log.delete();
      req_log.delete();
      m_pc         = entry & ~64'h3;
      m_out        = 0;
      m_drop       = 0;
      m_halt       = 0;
      resp_cyc     = -1;
      first_ov_cyc = -1;
    end else begin
      if (occupancy > DEPTH)      check("occupancy_bound", 64'(occupancy), 64'(DEPTH));
      if (halted && !m_halt)      check("halted_unexpected", {63'h0, halted}, 64'h0);
      if (mem_req_valid && m_out) check("second_outstanding_req", {63'h0, mem_req_valid}, 64'h0);
      if (mem_req_valid && m_halt) check("req_while_halted", {63'h0, mem_req_valid}, 64'h0);
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;

      // decoder consumes the head this cycle
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {63'h0, out_valid}, 64'h0);
        end else begin
          ent_t e, got;
          e = exp_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_instr", {32'h0, out_instr}, {32'h0, e.instr});
          got.pc    = out_pc;
          got.instr = out_instr;
          pop_log.push_back(got);
        end
      end

      // a line arrives: every word from the fetch PC to the line end is due
      if (mem_resp_valid) begin
        if (resp_cyc < 0) resp_cyc = cyc;
        if (m_drop) begin
          m_drop = 0;
        end else if (m_out && !redirect_valid) begin
          logic [63:0] base;
          base = m_pc & LINE_MASK;
          for (int i = int'(m_pc[5:2]); i < WPL; i++) begin
            ent_t e;
            e.pc    = base + 64'(4 * i);
            e.instr = mem_word(e.pc);
`ifdef FETCH_HALT_ON_ZERO_EN
            if (e.instr == 32'h0) begin
              m_halt = 1;
              break;
            end
`endif
            exp_q.push_back(e);
          end
          if (!m_halt) m_pc = base + 64'(LINE_BITS / 8);
        end
        m_out = 0;
      end

      // request accepted: it must target the line holding the fetch PC
      if (mem_req_valid && mem_req_ready) begin
        check("req_addr", mem_req_addr, m_pc & LINE_MASK);
        req_log.push_back(mem_req_addr);
        m_out = 1;
      end

      // redirect: queue emptied, fetch restarts, in-flight line becomes stale
      if (redirect_valid) begin
        exp_q.delete();
        m_pc   = redirect_pc & ~64'h3;
        m_halt = 0;
        if (m_out) m_drop = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [63:0] e);
    tick();
    reset          = 1'b0;
    entry          = e;
    redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("req_not_before_release_edge", {63'h0, mem_req_valid}, 64'h0);
    tick();
    check("req_valid_1_cycle_after_release", {63'h0, mem_req_valid}, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    entry          = 64'h1000;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    out_ready      = 1'b1;

    // reset state
    tick();
    tick();
    check("rst_out_instr", {32'h0, out_instr}, 64'h0);
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_req_addr", mem_req_addr, 64'h0);
    check("rst_halted", {63'h0, halted}, 64'h0);

    // T1: aligned entry, streaming
    resp_lat  = 1;
    out_ready = 1'b1;
    do_reset(64'h1000);
    check("t1_req_addr_now", mem_req_addr, 64'h1000);
    for (int n = 0; n < 200 && (pop_log.size() < 16 || req_log.size() < 2); n++) tick();
    check("t1_progress", {63'h0, pop_log.size() >= 16 && req_log.size() >= 2}, 64'h1);
    check("t1_req0", req_log[0], 64'h1000);
    check("t1_pc0", pop_log[0].pc, 64'h1000);
    check("t1_instr0", {32'h0, pop_log[0].instr}, 64'h13);
    check("t1_pc15", pop_log[15].pc, 64'h103C);
    check("t1_instr15", {32'h0, pop_log[15].instr}, 64'h22);
    check("t1_req1", req_log[1], 64'h1040);
    check("t1_resp_to_out_latency", 64'(first_ov_cyc - resp_cyc), 64'h2);

    // T2: entry inside the line -> only the last two words
    do_reset(64'h1038);
    for (int n = 0; n < 200 && pop_log.size() < 3; n++) tick();
    check("t2_req0", req_log[0], 64'h1000);
    check("t2_pc0", pop_log[0].pc, 64'h1038);
    check("t2_pc1", pop_log[1].pc, 64'h103C);
    check("t2_req1", req_log[1], 64'h1040);
    check("t2_pc2_next_line", pop_log[2].pc, 64'h1040);

    // T3: decoder stalled -> FIFO saturates, FILL holds
    out_ready = 1'b0;
    do_reset(64'h1000);
    for (int n = 0; n < 100 && occupancy != 4'(DEPTH); n++) tick();
    repeat (5) tick();
    check("t3_occupancy_full", 64'(occupancy), 64'h8);
    check("t3_no_req_when_full", {63'h0, mem_req_valid}, 64'h0);
    check("t3_single_req", 64'(req_log.size()), 64'h1);
    out_ready = 1'b1;
    tick();
    check("t3_push_pop_at_full", 64'(occupancy), 64'h8);
    for (int n = 0; n < 200 && pop_log.size() < 16; n++) tick();
    check("t3_pc8", pop_log[8].pc, 64'h1020);
    check("t3_pc15", pop_log[15].pc, 64'h103C);

    // T4: redirect while waiting for a line
    resp_lat  = 4;
    out_ready = 1'b1;
    do_reset(64'h1000);
    for (int n = 0; n < 50 && req_log.size() < 1; n++) tick();
    redirect_pc    = 64'h2006;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t4_out_valid_after_redirect", {63'h0, out_valid}, 64'h0);
    check("t4_no_req_while_stale", {63'h0, mem_req_valid}, 64'h0);
    for (int n = 0; n < 200 && pop_log.size() < 1; n++) tick();
    check("t4_req1", req_log[1], 64'h2000);
    check("t4_first_pc", pop_log[0].pc, 64'h2004);
    check("t4_first_instr", {32'h0, pop_log[0].instr}, 64'h414);
    resp_lat = 1;

    // T7: redirect while the FIFO is full
    out_ready = 1'b0;
    do_reset(64'h1000);
    for (int n = 0; n < 100 && occupancy != 4'(DEPTH); n++) tick();
    redirect_pc    = 64'h1100;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t7_out_valid_flushed", {63'h0, out_valid}, 64'h0);
    check("t7_occupancy_flushed", 64'(occupancy), 64'h0);
    out_ready = 1'b1;
    for (int n = 0; n < 100 && pop_log.size() < 1; n++) tick();
    check("t7_first_pc", pop_log[0].pc, 64'h1100);
    check("t7_first_instr", {32'h0, pop_log[0].instr}, 64'h53);

    // T5: asynchronous reset mid-FILL with five entries held
    out_ready = 1'b0;
    do_reset(64'h1000);
    for (int n = 0; n < 100 && occupancy != 4'd5; n++) tick();
    reset = 1'b0;
    #1;
    check("t5_occupancy_async", 64'(occupancy), 64'h0);
    check("t5_out_valid_async", {63'h0, out_valid}, 64'h0);
    check("t5_req_valid_async", {63'h0, mem_req_valid}, 64'h0);
    entry = 64'h3000;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t5_req_valid_after_release", {63'h0, mem_req_valid}, 64'h1);
    check("t5_req_addr_entry", mem_req_addr, 64'h3000);
    out_ready = 1'b1;
    for (int n = 0; n < 100 && pop_log.size() < 4; n++) tick();
    check("t5_first_pc", pop_log[0].pc, 64'h3000);

`ifdef FETCH_HALT_ON_ZERO_EN
    // T6: zero word at index 3 halts fetch
    zero_addr = 64'h100C;
    do_reset(64'h1000);
    repeat (30) tick();
    check("t6_halted", {63'h0, halted}, 64'h1);
    check("t6_no_req", {63'h0, mem_req_valid}, 64'h0);
    check("t6_words_out", 64'(pop_log.size()), 64'h3);
    check("t6_single_req", 64'(req_log.size()), 64'h1);
    redirect_pc    = 64'h1040;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t6_halted_cleared", {63'h0, halted}, 64'h0);
    for (int n = 0; n < 100 && pop_log.size() < 4; n++) tick();
    check("t6_restart_pc", pop_log[3].pc, 64'h1040);
`endif

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
